dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between two requesters: the SimpleRISC core's load/store path (port 0) and a debug/loader master (port 1) that preloads or inspects data memory. Grants are round-robin with an optional lock that lets port 1 hold the memory for a burst. Read data returns one cycle after the grant. The block sits between the core's address/store-data/load-data nets and `dmem`, and it produces the core's stall signal.

## Interface
- `AW`, 32: address width in bits.
- `DW`, 32: data width in bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `r0_req`, `r1_req` in 1 each: request; held until granted.
- `r0_we`, `r1_we` in 1 each: 1 means write, 0 means read.
- `r0_addr`, `r1_addr` in AW each: byte address.
- `r0_wdata`, `r1_wdata` in DW each: write data.
- `r1_lock` in 1: port 1 requests exclusive ownership.
- `r0_gnt`, `r1_gnt` out 1 each: transfer accepted this cycle.
- `r0_rvalid`, `r1_rvalid` out 1 each: read data valid.
- `r0_rdata`, `r1_rdata` out DW each: read data.
- `cpu_stall` out 1: equals `r0_req & ~r0_gnt`.
- `m_re`, `m_we` out 1 each: memory read and write strobes.
- `m_addr` out AW, `m_wdata` out DW: memory address and write data.
- `m_rdata` in DW: memory read data, registered by memory, valid the cycle after `m_re`.

## Operation
- Requester rule: `addr`, `we` and `wdata` stay stable while `req`=1 and `gnt`=0. Withdrawing a request before it is granted is illegal and is flagged by an assertion only.
- Arbitration is combinational in the request cycle. At most one `gnt` is high per cycle. `m_*` carries the winner's fields in the same cycle: `m_re = gnt & ~we`, `m_we = gnt & we`.
- Round-robin: register `last` holds the last granted port. On a conflict the port that is not `last` wins. A single requester always wins. `last` updates only on a grant.
- States:
  - `IDLE`: round-robin as above.
  - `LOCKED`: only port 1 may be granted. Port 0 is stalled.
- Transitions:
  - `IDLE` to `LOCKED`: `r1_gnt & r1_lock` in the same cycle.
  - `LOCKED` to `IDLE`: any cycle with `r1_lock`=0. That cycle already arbitrates as `IDLE`.
  - `r1_lock` without a port-1 grant does nothing.
- Read return: register `rd_pend` (1 bit) plus `rd_tag` (port id) is set on a read grant. Next cycle, `rN_rvalid`=1 for `N = rd_tag` and `rN_rdata = m_rdata`. The non-selected `rdata` output is 0.
- Pipelining: a new grant may issue in the same cycle that a previous read returns. Full throughput is one transfer per cycle.
- Writes produce no `rvalid`.

## Timing
- Reset values: `last`=1 (port 0 wins the first tie), state `IDLE`, `rd_pend`=0. All outputs are 0.
- Grant latency: 0 cycles (same cycle as `req`). Read latency: 1 cycle from `gnt` to `rvalid`.
- Simultaneous requests in `IDLE`: grants alternate, so a continuously requesting port waits at most 1 cycle.
- In `LOCKED`, port 0 starves until the lock drops. This is by design for debug bursts.
- Reset asserted mid-read: `rd_pend` clears immediately and the pending `rvalid` is never produced.
- Reset asserted mid-lock: the state returns to `IDLE` immediately.
- `m_addr` and `m_wdata` equal 0 when there is no grant. No X is propagated to the memory.

## Structure
- Shared header `arb.vh`: port-id defines `ARB_P0`=0 and `ARB_P1`=1, and state encodings `ARB_IDLE` and `ARB_LOCKED`.
- One sub-module, `rr_pick2`: a combinational 2-way round-robin picker (inputs `req[1:0]` and `last`; outputs `gnt[1:0]`).
- The FSM, read-tag pipeline and output muxing live in `dmem_arbiter`.

## Test plan
- Port 0 only, read address 0x10 where memory holds 0xDEADBEEF: `r0_gnt`=1 in cycle 0, `m_re`=1, `m_addr`=0x10; `r0_rvalid`=1 with `r0_rdata`=0xDEADBEEF in cycle 1; `cpu_stall`=0 throughout.
- Both ports request reads continuously, first cycle after reset: grant order is P0, P1, P0, P1. `cpu_stall` is high on alternate cycles. Each `rvalid` tag matches the grant one cycle earlier.
- Port 1 writes 0x5 to address 0x20 with `r1_lock`=1 for 4 cycles while port 0 requests: `r0_gnt`=0 for all 4 cycles. On the cycle `r1_lock` drops, `r0_gnt`=1. A port-0 read of 0x20 then returns 0x5.
- Back-to-back P0 read then P1 write: `m_we`=1 in cycle 1 while `r0_rvalid`=1 in the same cycle, with no data corruption.
- Reset pulse in the cycle after a read grant: `r0_rvalid` stays 0 and all outputs are 0. After release, the first tie goes to P0.
- No requests for 10 cycles: `m_re`=`m_we`=0, `m_addr`=0, and `last` is unchanged.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_pkg : port ids and FSM encoding for the dmem arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_arbiter_pkg;

   localparam logic ARB_P0 = 1'b0;
   localparam logic ARB_P1 = 1'b1;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Winner id from a one-hot (or empty) grant vector.
   function automatic logic grant_id(input logic [1:0] gnt);
      return gnt[1] ? ARB_P1 : ARB_P0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2 : combinational two-way round-robin picker                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // On a tie the port that was not granted last wins.
   assign gnt[0] = req[0] & (~req[1] | (last == ARB_P1));
   assign gnt[1] = req[1] & (~req[0] | (last == ARB_P0));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : shares the data-memory port between the core (P0) and |
// | the debug/loader master (P1); round-robin with a P1 burst lock.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstn,

   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,

   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   input  logic          r1_lock,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,

   output logic          cpu_stall,

   output logic          m_re,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   logic          r_last;
   logic          r_rd_pend;
   logic          r_rd_tag;

   logic          w_lock_hold;
   logic [1:0]    w_req;
   logic [1:0]    w_gnt;
   logic          w_any;
   logic          w_win;
   logic          w_win_we;
   logic [AW-1:0] w_win_addr;
   logic [DW-1:0] w_win_wdata;

   // ---------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------
   rr_pick2 u_pick (
      .req  (w_req),
      .last (r_last),
      .gnt  (w_gnt)
   );

   assign w_req       = {r1_req, r0_req & ~w_lock_hold};
   assign w_any       = |w_gnt;
   assign w_win       = grant_id(w_gnt);
   assign w_win_we    = (w_win == ARB_P1) ? r1_we    : r0_we;
   assign w_win_addr  = (w_win == ARB_P1) ? r1_addr  : r0_addr;
   assign w_win_wdata = (w_win == ARB_P1) ? r1_wdata : r0_wdata;

   assign r0_gnt    = w_gnt[0];
   assign r1_gnt    = w_gnt[1];
   assign cpu_stall = r0_req & ~w_gnt[0];

   // Memory side is forced to zero with no grant so nothing undefined leaks out.
   assign m_re    = w_any & ~w_win_we;
   assign m_we    = w_any &  w_win_we;
   assign m_addr  = w_any ? w_win_addr  : '0;
   assign m_wdata = w_any ? w_win_wdata : '0;

   // ---------------------------------------------------------------
   // Lock FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A dropped lock releases port 0 in the very same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_lock_hold = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_gnt[1] && r1_lock) begin
               w_state_nxt = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            w_lock_hold = r1_lock;
            if (!r1_lock) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Round-robin history and read-return tag
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last    <= ARB_P1;
         r_rd_pend <= 1'b0;
         r_rd_tag  <= ARB_P0;
      end else begin
         if (w_any) begin
            r_last <= w_win;
         end
         r_rd_pend <= w_any & ~w_win_we;
         r_rd_tag  <= w_win;
      end
   end

   assign r0_rvalid = r_rd_pend & (r_rd_tag == ARB_P0);
   assign r1_rvalid = r_rd_pend & (r_rd_tag == ARB_P1);
   assign r0_rdata  = r0_rvalid ? m_rdata : '0;
   assign r1_rdata  = r1_rvalid ? m_rdata : '0;

   // ---------------------------------------------------------------
   // Protocol checks
   // ---------------------------------------------------------------
   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn)
      !(r0_gnt && r1_gnt));

   a_r0_no_withdraw : assert property (@(posedge clk) disable iff (!rstn)
      (r0_req && !r0_gnt) |=> r0_req);

   a_r1_no_withdraw : assert property (@(posedge clk) disable iff (!rstn)
      (r1_req && !r1_gnt) |=> r1_req);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed self-checking bench for dmem_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          rstn;
   logic          r0_req, r0_we, r1_req, r1_we, r1_lock;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, cpu_stall;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          m_re, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] mem [0:63];

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .r0_req    (r0_req),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_lock   (r1_lock),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .cpu_stall (cpu_stall),
      .m_re      (m_re),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read memory model, one word per 4-byte address.
   always @(posedge clk) begin
      if (m_re) m_rdata <= mem[m_addr[7:2]];
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, " m_re"},      32'(m_re),      32'd0);
      check_eq({tag, " m_we"},      32'(m_we),      32'd0);
      check_eq({tag, " m_addr"},    m_addr,         32'd0);
      check_eq({tag, " m_wdata"},   m_wdata,        32'd0);
      check_eq({tag, " r0_gnt"},    32'(r0_gnt),    32'd0);
      check_eq({tag, " r1_gnt"},    32'(r1_gnt),    32'd0);
      check_eq({tag, " r0_rvalid"}, 32'(r0_rvalid), 32'd0);
      check_eq({tag, " r1_rvalid"}, 32'(r1_rvalid), 32'd0);
      check_eq({tag, " r0_rdata"},  r0_rdata,       32'd0);
      check_eq({tag, " r1_rdata"},  r1_rdata,       32'd0);
      check_eq({tag, " cpu_stall"}, 32'(cpu_stall), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[4] = 32'hDEADBEEF;          // byte address 0x10
      m_rdata  = '0;
      rstn     = 1'b0;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_lock = 1'b0;

      // Reset state
      @(negedge clk);
      check_quiet("reset");
      step();
      rstn = 1'b1;

      // Port 0 single read of 0x10
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
      @(negedge clk);
      check_eq("p0rd gnt",   32'(r0_gnt),    32'd1);
      check_eq("p0rd m_re",  32'(m_re),      32'd1);
      check_eq("p0rd m_addr", m_addr,        32'h10);
      check_eq("p0rd stall", 32'(cpu_stall), 32'd0);
      step();
      r0_req = 1'b0;
      @(negedge clk);
      check_eq("p0rd rvalid", 32'(r0_rvalid), 32'd1);
      check_eq("p0rd rdata",  r0_rdata,       32'hDEADBEEF);
      check_eq("p0rd r1v",    32'(r1_rvalid), 32'd0);
      check_eq("p0rd stall1", 32'(cpu_stall), 32'd0);
      step();

      // Ten idle cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle m_re",   32'(m_re), 32'd0);
         check_eq("idle m_we",   32'(m_we), 32'd0);
         check_eq("idle m_addr", m_addr,    32'd0);
         step();
      end

      // Locked P1 burst (last=P0, so P1 wins the opening tie)
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h20;
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h5; r1_lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("lock r0_gnt", 32'(r0_gnt),    32'd0);
         check_eq("lock r1_gnt", 32'(r1_gnt),    32'd1);
         check_eq("lock m_we",   32'(m_we),      32'd1);
         check_eq("lock stall",  32'(cpu_stall), 32'd1);
         step();
      end
      r1_req = 1'b0; r1_lock = 1'b0; r1_we = 1'b0;
      @(negedge clk);
      check_eq("unlock r0_gnt", 32'(r0_gnt), 32'd1);
      check_eq("unlock m_re",   32'(m_re),   32'd1);
      check_eq("unlock m_addr", m_addr,      32'h20);
      step();
      r0_req = 1'b0;
      @(negedge clk);
      check_eq("unlock rvalid", 32'(r0_rvalid), 32'd1);
      check_eq("unlock rdata",  r0_rdata,       32'h5);
      step();

      // Back-to-back P0 read then P1 write
      r0_req = 1'b1; r0_addr = 32'h10;
      @(negedge clk);
      check_eq("b2b r0_gnt", 32'(r0_gnt), 32'd1);
      step();
      r0_req = 1'b0;
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h30; r1_wdata = 32'h0000A5A5;
      @(negedge clk);
      check_eq("b2b r1_gnt",  32'(r1_gnt),    32'd1);
      check_eq("b2b m_we",    32'(m_we),      32'd1);
      check_eq("b2b m_addr",  m_addr,         32'h30);
      check_eq("b2b m_wdata", m_wdata,        32'h0000A5A5);
      check_eq("b2b r0v",     32'(r0_rvalid), 32'd1);
      check_eq("b2b r0data",  r0_rdata,       32'hDEADBEEF);
      check_eq("b2b r1v",     32'(r1_rvalid), 32'd0);
      step();
      r1_req = 1'b0; r1_we = 1'b0;
      r0_req = 1'b1; r0_addr = 32'h30;
      @(negedge clk);
      check_eq("b2b rd30 gnt", 32'(r0_gnt),    32'd1);
      check_eq("b2b wr no rv", 32'(r1_rvalid), 32'd0);
      step();
      r0_req = 1'b0;
      @(negedge clk);
      check_eq("b2b rd30 data", r0_rdata, 32'h0000A5A5);
      step();

      // Reset pulse the cycle after a read grant
      r0_req = 1'b1; r0_addr = 32'h10;
      @(negedge clk);
      check_eq("rst rd gnt", 32'(r0_gnt), 32'd1);
      step();
      r0_req = 1'b0;
      rstn   = 1'b0;
      @(negedge clk);
      check_quiet("midrst");
      step();
      rstn = 1'b1;

      // Continuous contention straight after reset: P0, P1, P0, P1
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h20;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("rr r0_gnt", 32'(r0_gnt),    (i % 2 == 0) ? 32'd1 : 32'd0);
         check_eq("rr r1_gnt", 32'(r1_gnt),    (i % 2 == 0) ? 32'd0 : 32'd1);
         check_eq("rr stall",  32'(cpu_stall), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i > 0) begin
            check_eq("rr r0v", 32'(r0_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("rr r1v", 32'(r1_rvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr r0data", r0_rdata, (i % 2 == 1) ? 32'hDEADBEEF : 32'd0);
            check_eq("rr r1data", r1_rdata, (i % 2 == 0) ? 32'h5 : 32'd0);
         end
         step();
      end
      r1_req = 1'b0;
      @(negedge clk);
      check_eq("rr tail r0_gnt", 32'(r0_gnt),    32'd1);
      check_eq("rr tail r1v",    32'(r1_rvalid), 32'd1);
      check_eq("rr tail r1data", r1_rdata,       32'h5);
      step();
      r0_req = 1'b0;
      @(negedge clk);
      check_eq("rr end r0v",    32'(r0_rvalid), 32'd1);
      check_eq("rr end r0data", r0_rdata,       32'hDEADBEEF);
      check_eq("rr end r1data", r1_rdata,       32'd0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
